// File: rtl/regfile_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_arbiter: shares a single-port register file between requesters A and B
// with round-robin/fixed-priority arbitration and a read-return timeout. rev 1.0
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int Width   = 8,
  parameter int Depth   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Prio_Mode,
  input  logic                     A_Req,
  input  logic                     B_Req,
  input  logic                     A_Wr,
  input  logic                     B_Wr,
  input  logic [$clog2(Depth)-1:0] A_Addr,
  input  logic [$clog2(Depth)-1:0] B_Addr,
  input  logic [Width-1:0]         A_Wr_D,
  input  logic [Width-1:0]         B_Wr_D,
  output logic                     A_Gnt,
  output logic                     B_Gnt,
  output logic [Width-1:0]         A_Rd_D,
  output logic [Width-1:0]         B_Rd_D,
  output logic                     A_Rd_D_VLD,
  output logic                     B_Rd_D_VLD,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [$clog2(Depth)-1:0] Addr,
  output logic [Width-1:0]         Wr_D,
  input  logic [Width-1:0]         Rd_D,
  input  logic                     Rd_D_VLD,
  output logic                     Timeout_Err
);

  localparam int         AW          = $clog2(Depth);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             owner_b, owner_b_nx;   // 1 = in-flight transaction belongs to B
  logic             last_b, last_b_nx;     // 1 = B was granted most recently
  logic [7:0]       tmo_cnt, tmo_cnt_nx;
  logic [7:0]       tmo_inc;
  logic             wr_en_nx, rd_en_nx, a_gnt_nx, b_gnt_nx;
  logic             a_vld_nx, b_vld_nx, tmo_err_nx;
  logic [AW-1:0]    addr_nx;
  logic [Width-1:0] wr_d_nx, a_rd_d_nx, b_rd_d_nx;
  logic             win_b, win_wr;

  assign tmo_inc = tmo_cnt + 8'd1;

  always_comb begin
    state_nx   = state;
    owner_b_nx = owner_b;
    last_b_nx  = last_b;
    tmo_cnt_nx = tmo_cnt;
    wr_en_nx   = 1'b0;
    rd_en_nx   = 1'b0;
    a_gnt_nx   = 1'b0;
    b_gnt_nx   = 1'b0;
    a_vld_nx   = 1'b0;
    b_vld_nx   = 1'b0;
    tmo_err_nx = 1'b0;
    addr_nx    = Addr;
    wr_d_nx    = Wr_D;
    a_rd_d_nx  = A_Rd_D;
    b_rd_d_nx  = B_Rd_D;
    win_b      = 1'b0;
    win_wr     = 1'b0;

    case (state)
      IDLE: begin
        if (A_Req || B_Req) begin
          // A tie goes to A in fixed mode, otherwise to whoever was not granted last.
          if (A_Req && B_Req) win_b = Prio_Mode ? 1'b0 : ~last_b;
          else                win_b = B_Req;
          win_wr     = win_b ? B_Wr : A_Wr;
          addr_nx    = win_b ? B_Addr : A_Addr;
          wr_d_nx    = win_b ? B_Wr_D : A_Wr_D;
          owner_b_nx = win_b;
          last_b_nx  = win_b;
          a_gnt_nx   = ~win_b;
          b_gnt_nx   = win_b;
          wr_en_nx   = win_wr;
          rd_en_nx   = ~win_wr;
          tmo_cnt_nx = 8'd0;
          state_nx   = win_wr ? WRITE : READ_WAIT;
        end
      end

      WRITE: begin
        state_nx = IDLE;
      end

      READ_WAIT: begin
        if (Rd_D_VLD) begin
          if (owner_b) begin
            b_rd_d_nx = Rd_D;
            b_vld_nx  = 1'b1;
          end else begin
            a_rd_d_nx = Rd_D;
            a_vld_nx  = 1'b1;
          end
          state_nx = IDLE;
        end else begin
          tmo_cnt_nx = tmo_inc;
          if (tmo_inc == TIMEOUT_CNT) begin
            // Abort: hand the owner a zero word so it is never left waiting.
            tmo_err_nx = 1'b1;
            if (owner_b) begin
              b_rd_d_nx = '0;
              b_vld_nx  = 1'b1;
            end else begin
              a_rd_d_nx = '0;
              a_vld_nx  = 1'b1;
            end
            state_nx = IDLE;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      owner_b     <= 1'b0;
      last_b      <= 1'b1;
      tmo_cnt     <= 8'd0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      A_Gnt       <= 1'b0;
      B_Gnt       <= 1'b0;
      A_Rd_D_VLD  <= 1'b0;
      B_Rd_D_VLD  <= 1'b0;
      Timeout_Err <= 1'b0;
      Addr        <= '0;
      Wr_D        <= '0;
      A_Rd_D      <= '0;
      B_Rd_D      <= '0;
    end else begin
      state       <= state_nx;
      owner_b     <= owner_b_nx;
      last_b      <= last_b_nx;
      tmo_cnt     <= tmo_cnt_nx;
      WrEn        <= wr_en_nx;
      RdEn        <= rd_en_nx;
      A_Gnt       <= a_gnt_nx;
      B_Gnt       <= b_gnt_nx;
      A_Rd_D_VLD  <= a_vld_nx;
      B_Rd_D_VLD  <= b_vld_nx;
      Timeout_Err <= tmo_err_nx;
      Addr        <= addr_nx;
      Wr_D        <= wr_d_nx;
      A_Rd_D      <= a_rd_d_nx;
      B_Rd_D      <= b_rd_d_nx;
    end
  end

endmodule
`default_nettype wire
